// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage operand/decode fields in, ID/EX control bundle
// and hazard/stall status out. master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int ALUOP_W = 2
);
    logic [6:0]         Op_i;
    logic [6:0]         Funct7_i;
    logic [4:0]         RS1addr_i;
    logic [4:0]         RS2addr_i;
    logic [4:0]         RDaddr_i;
    logic               Flush_i;
    logic               RegWrite_o;
    logic               MemtoReg_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic [ALUOP_W-1:0] ALUOp_o;
    logic               ALUSrc_o;
    logic               MulSel_o;
    logic [4:0]         RDaddr_o;
    logic               Branch_o;
    logic               Stall_o;
    logic               EXValid_o;

    modport master (
        output Op_i, Funct7_i, RS1addr_i, RS2addr_i,
        output RDaddr_i, Flush_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o,
        input  MemWrite_o, ALUOp_o, ALUSrc_o, MulSel_o,
        input  RDaddr_o, Branch_o, Stall_o, EXValid_o
    );

    modport slave (
        input  Op_i, Funct7_i, RS1addr_i, RS2addr_i,
        input  RDaddr_i, Flush_i,
        output RegWrite_o, MemtoReg_o, MemRead_o,
        output MemWrite_o, ALUOp_o, ALUSrc_o, MulSel_o,
        output RDaddr_o, Branch_o, Stall_o, EXValid_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ID-stage decoder + ID/EX control register with load-use
// bubbles, branch flush and multi-cycle MUL hold. Ports: clk_i, rst_i, bus.
module pipe_ctrl #(
    parameter int ALUOP_W    = 2,
    parameter int MUL_CYCLES = 3,
    parameter bit ENABLE_MUL = 1'b1
) (
    input logic        clk_i,
    input logic        rst_i,
    pipe_ctrl_if.slave bus
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic               regWrite;
        logic               memtoReg;
        logic               memRead;
        logic               memWrite;
        logic [ALUOP_W-1:0] aluOp;
        logic               aluSrc;
        logic               mulSel;
        logic [4:0]         rdAddr;
    } ctrlT;

    typedef enum logic {IDLE, BUSY} stateT;

    stateT             state;
    logic [CNT_W-1:0]  count;
    ctrlT              idEx;
    ctrlT              ctrl;
    logic              ctrlBranch;
    logic              rs2Used;
    logic              isR, isI, isLd, isSt, isBr;
    logic              isMulCode;
    logic              loadUse;
    logic              stall;

    assign isR  = (bus.Op_i == OP_R);
    assign isI  = (bus.Op_i == OP_I);
    assign isLd = (bus.Op_i == OP_LD);
    assign isSt = (bus.Op_i == OP_ST);
    assign isBr = (bus.Op_i == OP_BR);

    assign isMulCode = ENABLE_MUL && (bus.Funct7_i == 7'b0000001);

    always_comb begin
        ctrl       = '0;
        ctrlBranch = 1'b0;
        rs2Used    = 1'b0;
        unique case (1'b1)
            isR: begin
                ctrl.aluOp    = ALUOP_W'(2'b10);
                ctrl.regWrite = 1'b1;
                ctrl.mulSel   = isMulCode;
                ctrl.rdAddr   = bus.RDaddr_i;
                rs2Used       = 1'b1;
            end
            isI: begin
                ctrl.aluOp    = ALUOP_W'(2'b11);
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.rdAddr   = bus.RDaddr_i;
            end
            isLd: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.memtoReg = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.rdAddr   = bus.RDaddr_i;
            end
            isSt: begin
                ctrl.aluSrc   = 1'b1;
                ctrl.memWrite = 1'b1;
                ctrl.rdAddr   = bus.RDaddr_i;
                rs2Used       = 1'b1;
            end
            isBr: begin
                ctrl.aluOp    = ALUOP_W'(2'b01);
                ctrl.rdAddr   = bus.RDaddr_i;
                ctrlBranch    = 1'b1;
                rs2Used       = 1'b1;
            end
            default: ;
        endcase
    end

    // x0 never carries a real dependency, so a load to x0 never stalls.
    assign loadUse = idEx.memRead && (idEx.rdAddr != 5'd0)
                     && ((idEx.rdAddr == bus.RS1addr_i)
                     || (rs2Used && idEx.rdAddr == bus.RS2addr_i));

    assign stall         = loadUse || (state == BUSY);
    assign bus.Stall_o   = stall;
    assign bus.Branch_o  = ctrlBranch && !stall;
    assign bus.EXValid_o = (state == IDLE);

    assign bus.RegWrite_o = idEx.regWrite;
    assign bus.MemtoReg_o = idEx.memtoReg;
    assign bus.MemRead_o  = idEx.memRead;
    assign bus.MemWrite_o = idEx.memWrite;
    assign bus.ALUOp_o    = idEx.aluOp;
    assign bus.ALUSrc_o   = idEx.aluSrc;
    assign bus.MulSel_o   = idEx.mulSel;
    assign bus.RDaddr_o   = idEx.rdAddr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            count <= '0;
            idEx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (loadUse || bus.Flush_i) begin
                        idEx <= '0;
                    end else begin
                        idEx <= ctrl;
                        if (ctrl.mulSel && (MUL_CYCLES > 1)) begin
                            count <= CNT_W'(MUL_CYCLES - 1);
                            state <= BUSY;
                        end
                    end
                end
                // The MUL stays in ID/EX; the frozen ID instruction,
                // including any flush request, is ignored here.
                BUSY: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
